// File: rtl/exe_div_unit_pkg.sv
// Shared types for the EXE-stage iterative divider: FSM state encodings.
package exe_div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_BUSY = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_st_e;

endpackage

// File: rtl/exe_div_unit_if.sv
// Request/response bundle between EXE and the divider; slave side is the unit.
interface exe_div_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_tag, busy
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_tag, busy
  );
endinterface

// File: rtl/exe_div_unit_iter_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_dvs,
  input  logic             i_bit,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);
  logic [WIDTH+1:0] w_sh;
  logic [WIDTH:0]   w_diff;

  assign w_sh   = {i_rem, i_bit};
  assign o_qbit = (w_sh >= {2'b00, i_dvs});
  // Partial remainder stays below 2^WIDTH, so the dropped top bit never carries.
  assign w_diff = w_sh[WIDTH:0] - {1'b0, i_dvs};
  assign o_rem  = o_qbit ? w_diff : w_sh[WIDTH:0];
endmodule

// File: rtl/exe_div_unit.sv
// Iterative restoring divider with valid/ready handshakes, tag and flush cancel.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes on accept.
module exe_div_unit
  import exe_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  exe_div_unit_if.slave div
);
  localparam int CNT_W = $clog2(WIDTH);

  div_st_e          r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_quot, r_remo;
  logic [WIDTH:0]   r_rem;
  logic             r_qneg, r_rneg;
  logic [TAG_W-1:0] r_tag;

  logic             w_accept, w_last, w_fast, w_a_neg, w_b_neg, w_qbit;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_q_mag, w_div0_q;
  logic [WIDTH:0]   w_rem;

  assign w_accept = div.in_valid && div.in_ready;
  assign w_last   = (r_cnt == '0);
  assign w_a_neg  = div.in_signed && div.in_a[WIDTH-1];
  assign w_b_neg  = div.in_signed && div.in_b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -div.in_a : div.in_a;
  assign w_abs_b  = w_b_neg ? -div.in_b : div.in_b;
  assign w_div0_q = w_a_neg ? WIDTH'(1) : '1;

`ifdef DIV_ZERO_FAST_EN
  assign w_fast = (div.in_b == '0);
`else
  assign w_fast = 1'b0;
`endif

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_dvs  (r_dvs),
    .i_bit  (r_dvd[WIDTH-1]),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  // Dividend register doubles as the quotient shift register.
  assign w_q_mag = {r_dvd[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= DIV_ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = DIV_ST_IDLE;
    end else begin
      case (r_state)
        DIV_ST_IDLE: if (w_accept) w_next = w_fast ? DIV_ST_DONE : DIV_ST_BUSY;
        DIV_ST_BUSY: if (w_last)   w_next = DIV_ST_DONE;
        DIV_ST_DONE: if (div.out_ready) w_next = DIV_ST_IDLE;
        default:     w_next = DIV_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    div.in_ready  = (r_state == DIV_ST_IDLE) && !flush;
    div.out_valid = (r_state == DIV_ST_DONE);
    div.busy      = (r_state != DIV_ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_tag  <= '0;
      r_quot <= '0;
      r_remo <= '0;
    end else if (!flush) begin
      case (r_state)
        DIV_ST_IDLE: if (w_accept) begin
          r_dvd  <= w_abs_a;
          r_dvs  <= w_abs_b;
          r_rem  <= '0;
          r_qneg <= w_a_neg ^ w_b_neg;
          r_rneg <= w_a_neg;
          r_tag  <= div.in_tag;
          r_cnt  <= CNT_W'(WIDTH-1);
          if (w_fast) begin
            r_quot <= w_div0_q;
            r_remo <= div.in_a;
          end
        end
        DIV_ST_BUSY: begin
          r_dvd <= w_q_mag;
          r_rem <= w_rem;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_quot <= r_qneg ? -w_q_mag : w_q_mag;
            r_remo <= r_rneg ? -w_rem[WIDTH-1:0] : w_rem[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign div.out_quot = r_quot;
  assign div.out_rem  = r_remo;
  assign div.out_tag  = r_tag;
endmodule

// File: tb/tb_exe_div_unit.sv
// Directed + random checks of exe_div_unit against an arithmetic reference model.
module tb_exe_div_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int failures = 0;

  exe_div_unit_if #(.WIDTH(32), .TAG_W(5)) dif();

  exe_div_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .div    (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain HDL arithmetic; truncating '/' and dividend-signed '%'.
  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0];
      r = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called 1ns after a rising edge with the unit idle; returns 1ns after the consume edge.
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int hold);
    logic [31:0] eq, er;
    int lat, exp_lat;
    bit busy_ok, stable_ok;
    model(s, a, b, eq, er);
`ifdef DIV_ZERO_FAST_EN
    exp_lat = (b == 32'd0) ? 0 : 32;
`else
    exp_lat = 32;
`endif
    dif.in_signed = s; dif.in_a = a; dif.in_b = b; dif.in_tag = tag; dif.in_valid = 1'b1;
    #1;
    chk("in_ready_idle", {63'd0, dif.in_ready}, 64'd1);
    @(posedge clk); #1;
    // Scramble inputs after accept: they must not be resampled.
    dif.in_valid = 1'b0; dif.in_signed = ~s; dif.in_a = $urandom; dif.in_b = $urandom;
    lat = 0; busy_ok = 1'b1;
    while (!dif.out_valid && lat < 40) begin
      if (!dif.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_during_op", {63'd0, busy_ok}, 64'd1);
    chk("quot", {32'd0, dif.out_quot}, {32'd0, eq});
    chk("rem", {32'd0, dif.out_rem}, {32'd0, er});
    chk("tag", {59'd0, dif.out_tag}, {59'd0, tag});
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      dif.in_valid = 1'b1;
      #1;
      if (dif.in_ready !== 1'b0) stable_ok = 1'b0;
      @(posedge clk); #1;
      if (dif.out_valid !== 1'b1 || dif.out_quot !== eq || dif.out_rem !== er || dif.out_tag !== tag)
        stable_ok = 1'b0;
    end
    if (hold > 0) chk("hold_stable", {63'd0, stable_ok}, 64'd1);
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    chk("idle_after_consume", {62'd0, dif.out_valid, dif.busy}, 64'd0);
  endtask

  task automatic start_and_wait(input int n);
    dif.in_signed = 1'b0; dif.in_a = 32'd1000; dif.in_b = 32'd3; dif.in_tag = 5'h3; dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit ov_seen;
    dif.in_valid = 1'b0; dif.in_signed = 1'b0; dif.in_a = '0; dif.in_b = '0;
    dif.in_tag = '0; dif.out_ready = 1'b0;

    #12;
    chk("rst_out_valid", {63'd0, dif.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, dif.busy}, 64'd0);
    chk("rst_outs", {dif.out_quot, dif.out_rem}, 64'd0);
    chk("rst_tag", {59'd0, dif.out_tag}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, dif.in_ready}, 64'd1);

    do_op(1'b0, 32'd100, 32'd7, 5'h1A, 0);
    do_op(1'b1, -32'sd7, 32'd2, 5'h01, 0);
    do_op(1'b1, 32'd7, -32'sd2, 5'h02, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'h03, 0);
    do_op(1'b0, 32'h1234_5678, 32'd0, 5'h04, 0);
    do_op(1'b1, -32'sd5, 32'd0, 5'h05, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 5'h06, 0);

    // Flush in BUSY cycle 10: result dropped.
    start_and_wait(9);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {62'd0, dif.busy, dif.out_valid}, 64'd0);
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dif.out_valid || dif.busy) ov_seen = 1'b1;
    end
    chk("flush_no_result", {63'd0, ov_seen}, 64'd0);
    do_op(1'b0, 32'd9, 32'd3, 5'h09, 0);

    // Request presented during flush must not be taken.
    dif.in_valid = 1'b1; dif.in_a = 32'd50; dif.in_b = 32'd5; flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'd0, dif.in_ready}, 64'd0);
    @(posedge clk); #1;
    dif.in_valid = 1'b0; flush = 1'b0;
    chk("flush_no_accept", {63'd0, dif.busy}, 64'd0);

    // Back-pressure in DONE, then back-to-back op.
    do_op(1'b1, 32'd1000, -32'sd33, 5'h11, 5);
    do_op(1'b0, 32'd77, 32'd11, 5'h12, 0);

    // Asynchronous reset between edges mid-BUSY.
    start_and_wait(9);
    #3 resetn = 1'b0;
    #1;
    chk("arst_outs", {62'd0, dif.out_valid, dif.busy}, 64'd0);
    chk("arst_quot", {dif.out_quot, dif.out_rem}, 64'd0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    chk("arst_in_ready", {63'd0, dif.in_ready}, 64'd1);
    chk("arst_busy", {63'd0, dif.busy}, 64'd0);

    for (int k = 0; k < 24; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_op(1'($urandom_range(0, 1)), a, b, 5'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
